// File: rtl/mips_id_decq.sv
// Decode queue between IF and EX: decodes each instruction at enqueue, buffers the
// decoded records in a DEPTH-entry FIFO and presents the oldest one over valid/ready.
module mips_id_decq #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [ADDR_W-1:0]          in_pc_incr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [ADDR_W-1:0]          out_pc_incr,
    output logic [4:0]                 out_rs_idx,
    output logic [4:0]                 out_rt_idx,
    output logic [4:0]                 out_dst_idx,
    output logic                       out_dst_wen,
    output logic [ADDR_W-1:0]          out_imm,
    output logic                       out_bjp,
    output logic                       out_lsu,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef struct packed {
        logic [31:0]       inst;
        logic [ADDR_W-1:0] pc_incr;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        dst;
        logic              wen;
        logic [ADDR_W-1:0] imm;
        logic              bjp;
        logic              lsu;
    } rec_t;

    // Full MIPS-I decode of one instruction into a queue record.
    function automatic rec_t decode(input logic [31:0] inst, input logic [ADDR_W-1:0] pc);
        rec_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        logic       r_type, jr, jalr, op_imm, load, store, j, jal, branch, no_rd;
        op     = inst[31:26];
        fn     = inst[5:0];
        r_type = (op == 6'b000000);
        jr     = r_type && (fn == 6'b001000);
        jalr   = r_type && (fn == 6'b001001);
        op_imm = (op[5:3] == 3'b001);
        load   = (op[5:3] == 3'b100);
        store  = (op[5:3] == 3'b101);
        j      = (op == 6'b000010);
        jal    = (op == 6'b000011);
        branch = (op[5:3] == 3'b000) && !r_type && !j && !jal;
        // mult/div family and mthi/mtlo write HI/LO, not the register file
        no_rd  = jr || (fn[5:2] == 4'b0110) || (fn == 6'b010001) || (fn == 6'b010011);

        d         = '0;
        d.inst    = inst;
        d.pc_incr = pc;
        d.rs      = inst[25:21];
        d.rt      = inst[20:16];
        if (r_type && !no_rd) begin
            d.dst = inst[15:11];
        end else if (op_imm || load) begin
            d.dst = inst[20:16];
        end else if (jal) begin
            d.dst = 5'd31;
        end
        d.wen = (d.dst != 5'd0);

        if ((op_imm && !op[2]) || load || store) begin
            d.imm = {{(ADDR_W-16){inst[15]}}, inst[15:0]};
        end else if (op_imm && (op[2:0] != 3'b111)) begin
            d.imm = {{(ADDR_W-16){1'b0}}, inst[15:0]};
        end else if (op_imm) begin
            d.imm = {inst[15:0], {(ADDR_W-16){1'b0}}};
        end else if (branch) begin
            d.imm = {{(ADDR_W-18){inst[15]}}, inst[15:0], 2'b00};
        end else if (j || jal) begin
            d.imm = {pc[ADDR_W-1:ADDR_W-4], inst[25:0], 2'b00};
        end
        d.bjp = branch || j || jal || jr || jalr;
        d.lsu = load || store;
        return d;
    endfunction

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    rec_t             mem_q [DEPTH];
    rec_t             in_rec;
    rec_t             head_rec;
    rec_t             out_rec;
    logic             empty, full, push, pop, bypass, wr_en, rd_adv;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                      (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;
    assign bypass   = BYPASS && empty && push;
    assign out_valid = !flush && (!empty || bypass);
    assign pop      = out_valid && out_ready;
    // A bypassed record consumed in the same cycle never occupies a slot
    assign wr_en    = push && !(bypass && out_ready);
    assign rd_adv   = pop && !empty;
    assign count    = wr_ptr_q - rd_ptr_q;

    assign in_rec   = decode(in_inst, in_pc_incr);
    assign head_rec = mem_q[rd_ptr_q[IDX_W-1:0]];

    always_comb begin
        out_rec = '0;
        if (!empty) begin
            out_rec = head_rec;
        end else if (bypass) begin
            out_rec = in_rec;
        end
    end

    assign out_inst    = out_rec.inst;
    assign out_pc_incr = out_rec.pc_incr;
    assign out_rs_idx  = out_rec.rs;
    assign out_rt_idx  = out_rec.rt;
    assign out_dst_idx = out_rec.dst;
    assign out_dst_wen = out_rec.wen;
    assign out_imm     = out_rec.imm;
    assign out_bjp     = out_rec.bjp;
    assign out_lsu     = out_rec.lsu;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_adv) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[IDX_W-1:0]] <= in_rec;
    end

endmodule

// File: tb/tb_mips_id_decq.sv
// Self-checking bench for mips_id_decq: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_mips_id_decq;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic        wen;
        logic        bjp;
        logic        lsu;
    } ref_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, in_valid0, out_ready0;
    logic [31:0] in_inst, in_pc_incr;

    logic        in_ready, out_valid, out_dst_wen, out_bjp, out_lsu;
    logic [31:0] out_inst, out_pc_incr, out_imm;
    logic [4:0]  out_rs_idx, out_rt_idx, out_dst_idx;
    logic [2:0]  count;

    logic        in_ready0, out_valid0, out_dst_wen0, out_bjp0, out_lsu0;
    logic [31:0] out_inst0, out_pc_incr0, out_imm0;
    logic [4:0]  out_rs_idx0, out_rt_idx0, out_dst_idx0;
    logic [2:0]  count0;

    int          errors = 0;
    int          checks = 0;
    int          writes = 0;
    logic [63:0] q[$];

    always #5 clk = ~clk;

    mips_id_decq #(.DEPTH(DEPTH), .ADDR_W(32), .BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc_incr(in_pc_incr),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc_incr(out_pc_incr), .out_rs_idx(out_rs_idx), .out_rt_idx(out_rt_idx),
        .out_dst_idx(out_dst_idx), .out_dst_wen(out_dst_wen), .out_imm(out_imm),
        .out_bjp(out_bjp), .out_lsu(out_lsu), .count(count)
    );

    mips_id_decq #(.DEPTH(DEPTH), .ADDR_W(32), .BYPASS(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_inst(in_inst), .in_pc_incr(in_pc_incr),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_inst(out_inst0),
        .out_pc_incr(out_pc_incr0), .out_rs_idx(out_rs_idx0), .out_rt_idx(out_rt_idx0),
        .out_dst_idx(out_dst_idx0), .out_dst_wen(out_dst_wen0), .out_imm(out_imm0),
        .out_bjp(out_bjp0), .out_lsu(out_lsu0), .count(count0)
    );

    // Decode written from the instruction-set tables, one mnemonic group per branch.
    function automatic ref_t ref_dec(input logic [31:0] inst, input logic [31:0] pc);
        ref_t        r;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] se;
        op = inst[31:26];
        fn = inst[5:0];
        se = {{16{inst[15]}}, inst[15:0]};
        r = '0;
        r.inst = inst;
        r.pc   = pc;
        r.rs   = inst[25:21];
        r.rt   = inst[20:16];
        if (op == 6'h00) begin
            if (fn == 6'h08) r.bjp = 1'b1;
            else if (fn == 6'h09) begin r.bjp = 1'b1; r.dst = inst[15:11]; end
            else if (!(fn inside {6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13})) r.dst = inst[15:11];
        end else if (op == 6'h02 || op == 6'h03) begin
            r.bjp = 1'b1;
            r.imm = {pc[31:28], 28'(inst[25:0] * 4)};
            if (op == 6'h03) r.dst = 5'd31;
        end else if (op inside {[6'h01:6'h07]}) begin
            r.bjp = 1'b1;
            r.imm = se * 4;
        end else if (op inside {[6'h08:6'h0B]}) begin
            r.dst = inst[20:16];
            r.imm = se;
        end else if (op inside {[6'h0C:6'h0E]}) begin
            r.dst = inst[20:16];
            r.imm = 32'(inst[15:0]);
        end else if (op == 6'h0F) begin
            r.dst = inst[20:16];
            r.imm = 32'(inst[15:0]) * 65536;
        end else if (op inside {[6'h20:6'h27]}) begin
            r.dst = inst[20:16];
            r.imm = se;
            r.lsu = 1'b1;
        end else if (op inside {[6'h28:6'h2F]}) begin
            r.imm = se;
            r.lsu = 1'b1;
        end
        r.wen = (r.dst != 5'd0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic v, input logic r,
                         input logic [31:0] inst, input logic [31:0] pc);
        flush = fl; in_valid = v; out_ready = r; in_inst = inst; in_pc_incr = pc;
    endtask

    // Compare the BYPASS=1 instance with the model for the current inputs.
    task automatic mcheck();
        logic        ev;
        logic [63:0] h;
        ref_t        e;
        ev = !flush && (q.size() > 0 || in_valid);
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("count", 32'(count), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(!flush && q.size() < DEPTH));
        if (ev) begin
            h = (q.size() > 0) ? q[0] : {in_inst, in_pc_incr};
            e = ref_dec(h[63:32], h[31:0]);
            chk("inst", out_inst, e.inst);
            chk("pc_incr", out_pc_incr, e.pc);
            chk("rs", 32'(out_rs_idx), 32'(e.rs));
            chk("rt", 32'(out_rt_idx), 32'(e.rt));
            chk("dst", 32'(out_dst_idx), 32'(e.dst));
            chk("wen", 32'(out_dst_wen), 32'(e.wen));
            chk("imm", out_imm, e.imm);
            chk("bjp", 32'(out_bjp), 32'(e.bjp));
            chk("lsu", 32'(out_lsu), 32'(e.lsu));
        end else if (!flush) begin
            chk("idle_inst", out_inst, 32'h0);
            chk("idle_imm", out_imm, 32'h0);
            chk("idle_dst", 32'(out_dst_idx), 32'h0);
        end
    endtask

    task automatic update();
        if (flush) begin
            q.delete();
        end else begin
            if (in_valid && q.size() < DEPTH) begin
                if (!(q.size() == 0 && out_ready)) writes++;
                q.push_back({in_inst, in_pc_incr});
            end
            if (out_ready && q.size() > 0) void'(q.pop_front());
        end
    endtask

    task automatic finish_cycle();
        update();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic fl, input logic v, input logic r,
                         input logic [31:0] inst, input logic [31:0] pc);
        drive(fl, v, r, inst, pc);
        @(negedge clk);
        mcheck();
        finish_cycle();
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [5:0]  ops [21];
        logic [5:0]  fns [10];
        logic [31:0] x;
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h20, 6'h2B, 6'h28, 6'h10, 6'h3F, 6'h1C};
        fns = '{6'h08, 6'h09, 6'h18, 6'h1B, 6'h11, 6'h13, 6'h20, 6'h21, 6'h2A, 6'h00};
        x = $urandom();
        x[31:26] = ops[$urandom_range(0, 20)];
        if (x[31:26] == 6'h00) x[5:0] = fns[$urandom_range(0, 9)];
        return x;
    endfunction

    initial begin
        rst = 1'b1; in_valid0 = 1'b0; out_ready0 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_inst", out_inst, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset mid-stream with three entries queued
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, rnd_inst(), 32'h1000 + 32'(i * 4));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("pre_rst_count", 32'(count), 32'd3);
        #2; rst = 1'b1; #1;
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h1);
        q.delete();
        #1; rst = 1'b0;
        @(posedge clk); #1;

        // Same-cycle bypass of addiu $9,$0,-1 on an empty queue
        drive(1'b0, 1'b1, 1'b1, 32'h2409FFFF, 32'h00400004);
        @(negedge clk);
        mcheck();
        chk("byp_valid", 32'(out_valid), 32'h1);
        chk("byp_dst", 32'(out_dst_idx), 32'd9);
        chk("byp_wen", 32'(out_dst_wen), 32'h1);
        chk("byp_imm", out_imm, 32'hFFFFFFFF);
        finish_cycle();
        chk("byp_count", 32'(count), 32'h0);

        // Fill to DEPTH with jal / ori / lui / sw
        cycle(1'b0, 1'b1, 1'b0, 32'h0C000010, 32'h80000004);
        cycle(1'b0, 1'b1, 1'b0, 32'h35088000, 32'h80000008);
        cycle(1'b0, 1'b1, 1'b0, 32'h3C011234, 32'h8000000C);
        cycle(1'b0, 1'b1, 1'b0, 32'hAFA80004, 32'h80000010);
        // Full queue with pop and push offered: only the pop happens
        drive(1'b0, 1'b1, 1'b1, 32'h01095020, 32'h80000014);
        @(negedge clk);
        mcheck();
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        chk("jal_dst", 32'(out_dst_idx), 32'd31);
        chk("jal_imm", out_imm, 32'h80000040);
        chk("jal_bjp", 32'(out_bjp), 32'h1);
        finish_cycle();
        chk("after_full_pop", 32'(count), 32'd3);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
        mcheck();
        chk("ori_imm", out_imm, 32'h00008000);
        chk("ori_dst", 32'(out_dst_idx), 32'd8);
        finish_cycle();
        @(negedge clk);
        mcheck();
        chk("lui_imm", out_imm, 32'h12340000);
        chk("lui_dst", 32'(out_dst_idx), 32'd1);
        finish_cycle();
        @(negedge clk);
        mcheck();
        chk("sw_lsu", 32'(out_lsu), 32'h1);
        chk("sw_wen", 32'(out_dst_wen), 32'h0);
        chk("sw_rs", 32'(out_rs_idx), 32'd29);
        chk("sw_rt", 32'(out_rt_idx), 32'd8);
        chk("sw_imm", out_imm, 32'd4);
        finish_cycle();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Steady push+pop at occupancy 2
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, rnd_inst(), $urandom());
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1, rnd_inst(), $urandom());
        chk("steady_count", 32'(count), 32'd2);

        // Flush with three queued and a marker offered
        cycle(1'b0, 1'b1, 1'b0, rnd_inst(), 32'h2000);
        drive(1'b1, 1'b1, 1'b1, 32'h2402BEEF, 32'h3000);
        @(negedge clk);
        mcheck();
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        chk("flush_in_ready", 32'(in_ready), 32'h0);
        finish_cycle();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("post_flush_count", 32'(count), 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h8C430010, 32'h3004);
        cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

        // BYPASS=0 instance: push appears exactly one cycle later
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        in_valid0 = 1'b1; out_ready0 = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h2109FFF0, 32'h00500004);
        @(negedge clk);
        chk("nb_same_valid", 32'(out_valid0), 32'h0);
        chk("nb_same_count", 32'(count0), 32'h0);
        mcheck();
        finish_cycle();
        in_valid0 = 1'b0;
        @(negedge clk);
        chk("nb_next_valid", 32'(out_valid0), 32'h1);
        chk("nb_next_inst", out_inst0, 32'h2109FFF0);
        chk("nb_next_imm", out_imm0, 32'hFFFFFFF0);
        chk("nb_next_dst", 32'(out_dst_idx0), 32'd9);
        chk("nb_next_count", 32'(count0), 32'h1);
        mcheck();
        finish_cycle();
        @(negedge clk);
        chk("nb_drained", 32'(out_valid0), 32'h0);
        mcheck();
        finish_cycle();
        out_ready0 = 1'b0;

        // Random traffic with stalls and occasional flushes
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom() % 60) == 0, ($urandom() % 4) != 0, ($urandom() % 3) != 0,
                  rnd_inst(), $urandom());
        end
        chk("ptr_wraps", 32'(writes >= 4 * DEPTH), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
